// File: rtl/neo_coin_meter_pkg.sv
// Shared definitions for the coin-meter pulse generator: channel state encoding and timer sizing.
package neo_coin_meter_pkg;

  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } chan_state_e;

  // Terminal timer value for a phase lasting 'ticks' strobes.
  function automatic logic [TIMER_W-1:0] last_tick(input int ticks);
    return TIMER_W'(ticks - 1);
  endfunction

endpackage

// File: rtl/neo_coin_chan.sv
// One coin-meter channel: synchroniser, rising-edge detect, pending queue,
// pulse/gap sequencer and sticky overflow flag.
module neo_coin_chan
  import neo_coin_meter_pkg::*;
#(
  parameter int PULSE_TICKS = 50,
  parameter int GAP_TICKS   = 50,
  parameter int PEND_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              TICK_EN,
  input  logic              COUNTER,
  output logic              nMETER,
  output logic [PEND_W-1:0] PENDING,
  output logic              OVERFLOW
);

  localparam logic [TIMER_W-1:0] PULSE_LAST = last_tick(PULSE_TICKS);
  localparam logic [TIMER_W-1:0] GAP_LAST   = last_tick(GAP_TICKS);
  localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [PEND_W-1:0]  PEND_ZERO  = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0]  PEND_ONE   = PEND_W'(1);
  localparam logic [PEND_W-1:0]  PEND_FULL  = {PEND_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [PEND_W-1:0]      pend_q, pend_d;
  logic                   ovf_q, ovf_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  chan_state_e            state_q, state_d;
  logic                   nmeter_q, nmeter_d;
  logic                   inc_s, dec_s;

  // Next-state logic: edge detect, sequencer, pending counter.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], COUNTER};
    prev_d   = sync_q[SYNC_STAGES-1];
    inc_s    = sync_q[SYNC_STAGES-1] & ~prev_q;
    state_d  = state_q;
    timer_d  = timer_q;
    dec_s    = 1'b0;
    pend_d   = pend_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (pend_q != PEND_ZERO) begin
          state_d = ST_PULSE;
          timer_d = TIMER_ZERO;
          dec_s   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (TICK_EN && (timer_q == PULSE_LAST)) begin
          state_d = ST_GAP;
          timer_d = TIMER_ZERO;
        end else if (TICK_EN) begin
          timer_d = timer_q + TIMER_ONE;
        end else begin
          timer_d = timer_q;
        end
      end
      ST_GAP: begin
        // The next queued increment starts on the very edge the gap expires.
        if (TICK_EN && (timer_q == GAP_LAST)) begin
          timer_d = TIMER_ZERO;
          if (pend_q != PEND_ZERO) begin
            state_d = ST_PULSE;
            dec_s   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (TICK_EN) begin
          timer_d = timer_q + TIMER_ONE;
        end else begin
          timer_d = timer_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = TIMER_ZERO;
      end
    endcase

    if (inc_s && !dec_s) begin
      if (pend_q == PEND_FULL) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_ONE;
      end
    end else if (dec_s && !inc_s) begin
      pend_d = pend_q - PEND_ONE;
    end else begin
      pend_d = pend_q;
    end

    nmeter_d = (state_d != ST_PULSE);
  end

  // Channel state registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      sync_q   <= {SYNC_STAGES{1'b0}};
      prev_q   <= 1'b0;
      pend_q   <= PEND_ZERO;
      ovf_q    <= 1'b0;
      timer_q  <= TIMER_ZERO;
      state_q  <= ST_IDLE;
      nmeter_q <= 1'b1;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      timer_q  <= timer_d;
      state_q  <= state_d;
      nmeter_q <= nmeter_d;
    end
  end

  assign nMETER   = nmeter_q;
  assign PENDING  = pend_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: rtl/neo_coin_meter.sv
// Coin-meter and lockout driver: two independent meter channels plus
// synchronised, registered lockout solenoid drives.
module neo_coin_meter
  import neo_coin_meter_pkg::*;
#(
  parameter int PULSE_TICKS = 50,
  parameter int GAP_TICKS   = 50,
  parameter int PEND_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              TICK_EN,
  input  logic              COUNTER1,
  input  logic              COUNTER2,
  input  logic              LOCKOUT1,
  input  logic              LOCKOUT2,
  output logic              nMETER1,
  output logic              nMETER2,
  output logic              nLOCK1,
  output logic              nLOCK2,
  output logic [PEND_W-1:0] PENDING1,
  output logic [PEND_W-1:0] PENDING2,
  output logic [1:0]        OVERFLOW
);

  logic [SYNC_STAGES-1:0] lock1_sync_q, lock1_sync_d;
  logic [SYNC_STAGES-1:0] lock2_sync_q, lock2_sync_d;
  logic [1:0]             nlock_q, nlock_d;
  logic                   ovf1_s, ovf2_s;

  neo_coin_chan #(
    .PULSE_TICKS(PULSE_TICKS), .GAP_TICKS(GAP_TICKS),
    .PEND_W(PEND_W), .SYNC_STAGES(SYNC_STAGES)
  ) u_chan1 (
    .CLK(CLK), .nRESET(nRESET), .TICK_EN(TICK_EN), .COUNTER(COUNTER1),
    .nMETER(nMETER1), .PENDING(PENDING1), .OVERFLOW(ovf1_s)
  );

  neo_coin_chan #(
    .PULSE_TICKS(PULSE_TICKS), .GAP_TICKS(GAP_TICKS),
    .PEND_W(PEND_W), .SYNC_STAGES(SYNC_STAGES)
  ) u_chan2 (
    .CLK(CLK), .nRESET(nRESET), .TICK_EN(TICK_EN), .COUNTER(COUNTER2),
    .nMETER(nMETER2), .PENDING(PENDING2), .OVERFLOW(ovf2_s)
  );

  // Lockout synchronisers feeding the inverted solenoid drive register.
  always_comb begin
    lock1_sync_d = {lock1_sync_q[SYNC_STAGES-2:0], LOCKOUT1};
    lock2_sync_d = {lock2_sync_q[SYNC_STAGES-2:0], LOCKOUT2};
    nlock_d      = {~lock2_sync_q[SYNC_STAGES-1], ~lock1_sync_q[SYNC_STAGES-1]};
  end

  // Lockout registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      lock1_sync_q <= {SYNC_STAGES{1'b0}};
      lock2_sync_q <= {SYNC_STAGES{1'b0}};
      nlock_q      <= 2'b11;
    end else begin
      lock1_sync_q <= lock1_sync_d;
      lock2_sync_q <= lock2_sync_d;
      nlock_q      <= nlock_d;
    end
  end

  assign nLOCK1   = nlock_q[0];
  assign nLOCK2   = nlock_q[1];
  assign OVERFLOW = {ovf2_s, ovf1_s};

endmodule

// File: tb/tb_neo_coin_meter.sv
// Self-checking bench for neo_coin_meter: directed scenarios plus random traffic
// compared every cycle against a countdown-based behavioural model.
module tb_neo_coin_meter;

  localparam int PULSE = 3;
  localparam int GAP   = 2;
  localparam int PW    = 4;
  localparam int PMAX  = 15;

  logic          clk = 1'b0;
  logic          nrst, tick, c1, c2, l1, l2;
  logic          nm1, nm2, nl1, nl2;
  logic [PW-1:0] pend1, pend2;
  logic [1:0]    ovf;

  int errors = 0;
  int checks = 0;
  int peak;

  // Model state: samples of each input at the previous three edges, and per-channel
  // queue depth plus remaining pulse/gap ticks.
  bit cs[2][3];
  bit ls[2][3];
  int m_pend[2];
  int m_pl[2];
  int m_gl[2];
  bit m_ovf[2];
  bit m_nlock[2];

  always #5 clk = ~clk;

  neo_coin_meter #(
    .PULSE_TICKS(PULSE), .GAP_TICKS(GAP), .PEND_W(PW), .SYNC_STAGES(2)
  ) dut (
    .CLK(clk), .nRESET(nrst), .TICK_EN(tick),
    .COUNTER1(c1), .COUNTER2(c2), .LOCKOUT1(l1), .LOCKOUT2(l2),
    .nMETER1(nm1), .nMETER2(nm2), .nLOCK1(nl1), .nLOCK2(nl2),
    .PENDING1(pend1), .PENDING2(pend2), .OVERFLOW(ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit cin[2];
    bit lin[2];
    bit rise;
    bit dec;
    int p;
    cin[0] = c1; cin[1] = c2;
    lin[0] = l1; lin[1] = l2;
    for (int ch = 0; ch < 2; ch++) begin
      if (!nrst) begin
        m_pend[ch] = 0; m_pl[ch] = 0; m_gl[ch] = 0;
        m_ovf[ch] = 1'b0; m_nlock[ch] = 1'b1;
        for (int k = 0; k < 3; k++) begin
          cs[ch][k] = 1'b0;
          ls[ch][k] = 1'b0;
        end
      end else begin
        rise = cs[ch][1] && !cs[ch][2];
        m_nlock[ch] = !ls[ch][1];
        cs[ch][2] = cs[ch][1]; cs[ch][1] = cs[ch][0]; cs[ch][0] = cin[ch];
        ls[ch][2] = ls[ch][1]; ls[ch][1] = ls[ch][0]; ls[ch][0] = lin[ch];
        dec = 1'b0;
        if (m_pl[ch] > 0) begin
          if (tick) begin
            m_pl[ch]--;
            if (m_pl[ch] == 0) m_gl[ch] = GAP;
          end
        end else if (m_gl[ch] > 0) begin
          if (tick) begin
            m_gl[ch]--;
            if (m_gl[ch] == 0 && m_pend[ch] > 0) begin
              m_pl[ch] = PULSE;
              dec = 1'b1;
            end
          end
        end else if (m_pend[ch] > 0) begin
          m_pl[ch] = PULSE;
          dec = 1'b1;
        end
        p = m_pend[ch] - (dec ? 1 : 0);
        if (rise) begin
          if (p == PMAX) m_ovf[ch] = 1'b1;
          else p++;
        end
        m_pend[ch] = p;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check("nmeter", {30'd0, nm2, nm1}, {30'd0, (m_pl[1] == 0), (m_pl[0] == 0)});
    check("nlock", {30'd0, nl2, nl1}, {30'd0, m_nlock[1], m_nlock[0]});
    check("pending1", {28'd0, pend1}, m_pend[0]);
    check("pending2", {28'd0, pend2}, m_pend[1]);
    check("overflow", {30'd0, ovf}, {30'd0, m_ovf[1], m_ovf[0]});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    nrst = 1'b0; tick = 1'b1; c1 = 1'b1; c2 = 1'b1; l1 = 1'b1; l2 = 1'b1;

    // Reset with all inputs high.
    run(2);
    check("rst_nmeter", {30'd0, nm2, nm1}, 32'd3);
    check("rst_nlock", {30'd0, nl2, nl1}, 32'd3);
    check("rst_pending", {24'd0, pend2, pend1}, 32'd0);
    check("rst_overflow", {30'd0, ovf}, 32'd0);
    c1 = 1'b0; c2 = 1'b0; l1 = 1'b0; l2 = 1'b0; nrst = 1'b1;
    run(6);

    // Single coin on channel 1.
    c1 = 1'b1;
    run(3);
    check("single_pend_up", {28'd0, pend1}, 32'd1);
    check("single_pre_pulse", {31'd0, nm1}, 32'd1);
    step();
    check("single_pulse_start", {31'd0, nm1}, 32'd0);
    check("single_pend_down", {28'd0, pend1}, 32'd0);
    run(2);
    check("single_pulse_held", {31'd0, nm1}, 32'd0);
    step();
    check("single_pulse_end", {31'd0, nm1}, 32'd1);
    check("single_ch2_idle", {31'd0, nm2}, 32'd1);
    run(6);

    // Burst of three rises two clocks apart.
    c1 = 1'b0;
    step();
    peak = 0;
    for (int i = 0; i < 3; i++) begin
      c1 = 1'b1; step();
      if (int'(pend1) > peak) peak = int'(pend1);
      c1 = 1'b0; step();
      if (int'(pend1) > peak) peak = int'(pend1);
    end
    for (int i = 0; i < 25; i++) begin
      step();
      if (int'(pend1) > peak) peak = int'(pend1);
    end
    check("burst_peak", peak, 32'd2);
    check("burst_final", {28'd0, pend1}, 32'd0);

    // Saturation while the pulse is frozen by TICK_EN low.
    tick = 1'b0;
    c1 = 1'b1;
    run(4);
    for (int i = 0; i < 17; i++) begin
      c1 = 1'b0; step();
      c1 = 1'b1; step();
    end
    run(4);
    check("sat_pending", {28'd0, pend1}, 32'd15);
    check("sat_overflow", {30'd0, ovf}, 32'd1);
    tick = 1'b1;
    run(90);
    check("sat_drained", {28'd0, pend1}, 32'd0);
    check("sat_sticky", {30'd0, ovf}, 32'd1);

    // Reset during the second clock of a pulse.
    c1 = 1'b0;
    run(3);
    c1 = 1'b1;
    run(4);
    check("mid_pulse_low", {31'd0, nm1}, 32'd0);
    step();
    nrst = 1'b0; c1 = 1'b0;
    step();
    check("mid_rst_nmeter", {31'd0, nm1}, 32'd1);
    check("mid_rst_pending", {28'd0, pend1}, 32'd0);
    nrst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("post_rst_quiet", {31'd0, nm1}, 32'd1);
    end

    // Lockout 2 rise and fall latency.
    l2 = 1'b1;
    run(2);
    check("lock_rise_early", {31'd0, nl2}, 32'd1);
    step();
    check("lock_rise", {31'd0, nl2}, 32'd0);
    l2 = 1'b0;
    run(2);
    check("lock_fall_early", {31'd0, nl2}, 32'd0);
    step();
    check("lock_fall", {31'd0, nl2}, 32'd1);
    check("lock_meters", {30'd0, nm2, nm1}, 32'd3);

    // Random traffic on all inputs, including sparse resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3) == 0) c1 = ~c1;
      if ($urandom_range(4) == 0) c2 = ~c2;
      if ($urandom_range(15) == 0) l1 = ~l1;
      if ($urandom_range(15) == 0) l2 = ~l2;
      tick = ($urandom_range(2) != 0);
      nrst = ($urandom_range(499) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
